// File: rtl/sobel_edge_3x3.sv
// 3x3 Sobel edge detector: builds a window from the current row plus two line-buffer rows,
// thresholds |Gx|+|Gy| to a binary pixel and delays de/hs/vs by the same 5-clock latency.
module sobel_edge_3x3 #(
    parameter int   DW     = 8,
    parameter int   CW     = 11,
    parameter logic VS_POL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          de_i,
    input  logic          hs_i,
    input  logic          vs_i,
    input  logic [DW-1:0] cur_i,
    input  logic [DW-1:0] row1_i,
    input  logic [DW-1:0] row2_i,
    input  logic [CW-1:0] threshold_i,
    output logic          de_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic [DW-1:0] edge_o
);

    localparam int SW = DW + 2;
    localparam int MW = DW + 3;
    localparam int KW = (MW > CW) ? MW : CW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Streaming interface, no back-pressure: a pixel is present whenever de_i=1 and every
    // stage advances each clock; de/hs/vs travel alongside the data as sideband.

    // S0: align the current row with the line-buffer rows, which arrive one clock later.
    logic [DW-1:0] cur_d;
    logic          de_d, hs_d, vs_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_d <= '0;
            de_d  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            cur_d <= cur_i;
            de_d  <= de_i;
            hs_d  <= hs_i;
            vs_d  <= vs_i;
        end
    end

    // S1: window, position counters and per-frame threshold.
    logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic          de_w, hs_w, vs_w, valid_w, vs_prev;
    logic [CW-1:0] col_cnt, row_cnt, thr_q;
    logic          frame_start, de_fall;

    assign frame_start = (vs_d == VS_POL) && (vs_prev != VS_POL);
    assign de_fall     = de_w && !de_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p11     <= '0; p12 <= '0; p13 <= '0;
            p21     <= '0; p22 <= '0; p23 <= '0;
            p31     <= '0; p32 <= '0; p33 <= '0;
            de_w    <= 1'b0;
            hs_w    <= 1'b0;
            vs_w    <= 1'b0;
            valid_w <= 1'b0;
            vs_prev <= ~VS_POL;
            col_cnt <= '0;
            row_cnt <= '0;
            thr_q   <= '0;
        end else begin
            de_w    <= de_d;
            hs_w    <= hs_d;
            vs_w    <= vs_d;
            vs_prev <= vs_d;
            // Border pixels lack a full neighbourhood, so they never produce an edge.
            valid_w <= de_d && (row_cnt >= CW'(2)) && (col_cnt >= CW'(2));
            if (de_d) begin
                p11 <= p12; p12 <= p13; p13 <= row2_i;
                p21 <= p22; p22 <= p23; p23 <= row1_i;
                p31 <= p32; p32 <= p33; p33 <= cur_d;
                if (col_cnt != CNT_MAX) col_cnt <= col_cnt + 1'b1;
            end else begin
                col_cnt <= '0;
            end
            // Frame start outranks a same-cycle end of line.
            if (frame_start) begin
                row_cnt <= '0;
                thr_q   <= threshold_i;
            end else if (de_fall && row_cnt != CNT_MAX) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // S2: positive and negative halves of both kernels, kept unsigned.
    logic [SW-1:0] gx_p, gx_n, gy_p, gy_n;
    logic          de_s2, hs_s2, vs_s2, valid_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gx_p     <= '0;
            gx_n     <= '0;
            gy_p     <= '0;
            gy_n     <= '0;
            de_s2    <= 1'b0;
            hs_s2    <= 1'b0;
            vs_s2    <= 1'b0;
            valid_s2 <= 1'b0;
        end else begin
            gx_p     <= SW'(p13) + (SW'(p23) << 1) + SW'(p33);
            gx_n     <= SW'(p11) + (SW'(p21) << 1) + SW'(p31);
            gy_p     <= SW'(p31) + (SW'(p32) << 1) + SW'(p33);
            gy_n     <= SW'(p11) + (SW'(p12) << 1) + SW'(p13);
            de_s2    <= de_w;
            hs_s2    <= hs_w;
            vs_s2    <= vs_w;
            valid_s2 <= valid_w;
        end
    end

    // S3: absolute gradients.
    logic [SW-1:0] ax, ay;
    logic          de_s3, hs_s3, vs_s3, valid_s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ax       <= '0;
            ay       <= '0;
            de_s3    <= 1'b0;
            hs_s3    <= 1'b0;
            vs_s3    <= 1'b0;
            valid_s3 <= 1'b0;
        end else begin
            ax       <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
            ay       <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
            de_s3    <= de_s2;
            hs_s3    <= hs_s2;
            vs_s3    <= vs_s2;
            valid_s3 <= valid_s2;
        end
    end

    // S4: magnitude and strict threshold compare.
    logic [MW-1:0] mag;
    logic [KW-1:0] mag_k, thr_k;

    assign mag   = MW'(ax) + MW'(ay);
    assign mag_k = KW'(mag);
    assign thr_k = KW'(thr_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_o <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
        end else begin
            edge_o <= (valid_s3 && (mag_k > thr_k)) ? '1 : '0;
            de_o   <= de_s3;
            hs_o   <= hs_s3;
            vs_o   <= vs_s3;
        end
    end

endmodule

// File: tb/tb_sobel_edge_3x3.sv
// Bench for sobel_edge_3x3: random-blanking video frames, a kernel-convolution reference
// model feeding an expected queue, and a monitor comparing every output cycle.
module tb_sobel_edge_3x3;

    localparam int DW = 8;
    localparam int CW = 11;
    localparam int W  = DW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [DW-1:0] cur_i = '0, row1_i = '0, row2_i = '0;
    logic [CW-1:0] threshold_i = '0;
    logic          de_o, hs_o, vs_o;
    logic [DW-1:0] edge_o;

    sobel_edge_3x3 #(.DW(DW), .CW(CW), .VS_POL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .cur_i(cur_i), .row1_i(row1_i), .row2_i(row2_i), .threshold_i(threshold_i),
        .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .edge_o(edge_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: one entry {de, hs, vs, edge} per driven cycle, due 5 clocks later.
    logic [W-1:0] exp_q[$];
    int n_chk = 0, n_pass = 0, ff_cnt = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] mon_e, mon_g;

    // Reference model state, in terms of the video stream.
    int m_row, m_col, m_thr;
    bit m_pde, m_pvs;
    int m_win[3][3];
    int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int ky[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    logic [DW-1:0] pend1 = '0, pend2 = '0;
    logic [DW-1:0] img[16][32];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_g = {de_o, hs_o, vs_o, edge_o};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_queue t=%0t got=%h exp=<empty>", $time, mon_g);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g === mon_e) n_pass++;
                else $display("FAIL out t=%0t got de/hs/vs/edge=%b/%b/%b/%h exp=%b/%b/%b/%h",
                              $time, de_o, hs_o, vs_o, edge_o,
                              mon_e[W-1], mon_e[W-2], mon_e[W-3], mon_e[DW-1:0]);
            end
            if (edge_o == 8'hFF) ff_cnt++;
        end
    end

    // Drives one clock of stimulus; r1n/r2n are the line-buffer values belonging to this
    // pixel, presented on the following clock as the real line buffer would.
    task automatic drive_cycle(input bit rst, input bit de, input bit hs, input bit vs,
                               input logic [DW-1:0] cur, input logic [DW-1:0] r1n,
                               input logic [DW-1:0] r2n, input int thr);
        int gx, gy, mag;
        logic [DW-1:0] edg;
        rst_n = rst; de_i = de; hs_i = hs; vs_i = vs;
        cur_i = cur; row1_i = pend1; row2_i = pend2; threshold_i = thr[CW-1:0];
        edg = '0;
        if (!rst) begin
            for (int i = 0; i < 4; i++)
                if (exp_q.size() > i) exp_q[exp_q.size()-1-i] = '0;
            exp_q.push_back('0);
            m_row = 0; m_col = 0; m_thr = 0; m_pde = 1'b0; m_pvs = 1'b0;
        end else begin
            if (vs && !m_pvs) begin
                m_row = 0;
                m_thr = thr;
            end else if (!de && m_pde && m_row < 2047) begin
                m_row++;
            end
            if (de) begin
                for (int i = 0; i < 3; i++) begin
                    m_win[i][0] = m_win[i][1];
                    m_win[i][1] = m_win[i][2];
                end
                m_win[0][2] = int'(r2n);
                m_win[1][2] = int'(r1n);
                m_win[2][2] = int'(cur);
                if (m_row >= 2 && m_col >= 2) begin
                    gx = 0; gy = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++) begin
                            gx += kx[i][j] * m_win[i][j];
                            gy += ky[i][j] * m_win[i][j];
                        end
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (mag > m_thr) edg = 8'hFF;
                end
                if (m_col < 2047) m_col++;
            end else begin
                m_col = 0;
            end
            exp_q.push_back({de, hs, vs, edg});
            m_pde = de; m_pvs = vs;
        end
        pend1 = r1n; pend2 = r2n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int thr, input bit hs, input bit vs);
        drive_cycle(1'b1, 1'b0, hs, vs, DW'($urandom_range(0, 255)),
                    DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), thr);
    endtask

    // pat: 0 flat 100, 1 step at column 4, 2 checkerboard of 2x2 blocks, 3 random.
    task automatic drive_frame(input int w, input int h, input int pat, input int thr_a,
                               input int thr_b, input int thr_row, input int rst_row);
        int thr;
        logic [DW-1:0] r1, r2;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                case (pat)
                    0: img[r][c] = 8'd100;
                    1: img[r][c] = (c < 4) ? 8'd0 : 8'd255;
                    2: img[r][c] = (((r / 2) + (c / 2)) % 2 == 1) ? 8'd255 : 8'd0;
                    default: img[r][c] = DW'($urandom_range(0, 255));
                endcase
        repeat (2) idle(thr_a, 1'b0, 1'b0);
        repeat (3) idle(thr_a, 1'b0, 1'b1);
        repeat (3) idle(thr_a, 1'b0, 1'b0);
        for (int r = 0; r < h; r++) begin
            thr = (r >= thr_row) ? thr_b : thr_a;
            repeat (2) idle(thr, 1'b1, 1'b0);
            repeat ($urandom_range(1, 3)) idle(thr, 1'b0, 1'b0);
            for (int c = 0; c < w; c++) begin
                r1 = (r >= 1) ? img[r-1][c] : DW'($urandom_range(0, 255));
                r2 = (r >= 2) ? img[r-2][c] : DW'($urandom_range(0, 255));
                drive_cycle(!(r == rst_row && c >= 5 && c < 8), 1'b1, 1'b0, 1'b0,
                            img[r][c], r1, r2, thr);
            end
            repeat ($urandom_range(2, 4)) idle(thr, 1'b0, 1'b0);
        end
        repeat (8) idle(thr, 1'b0, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        repeat (5) exp_q.push_back('0);
        mon_en = 1'b1;
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h33, 0);
        check("reset_edge", int'(edge_o), 0);
        check("reset_sync", int'({de_o, hs_o, vs_o}), 0);
        repeat (3) idle(0, 1'b0, 1'b0);

        ff_cnt = 0; drive_frame(16, 8, 0, 10, 10, 99, 99);
        check("flat_edges", ff_cnt, 0);

        ff_cnt = 0; drive_frame(16, 8, 1, 1019, 1019, 99, 99);
        check("step_1019_edges", ff_cnt, 12);

        ff_cnt = 0; drive_frame(16, 8, 1, 1020, 1020, 99, 99);
        check("step_1020_edges", ff_cnt, 0);

        ff_cnt = 0; drive_frame(12, 8, 2, 0, 0, 99, 99);
        check("checker_has_edges", int'(ff_cnt > 0), 1);

        ff_cnt = 0; drive_frame(16, 8, 1, 1019, 2000, 4, 99);
        check("thr_midframe_edges", ff_cnt, 12);
        ff_cnt = 0; drive_frame(16, 8, 1, 2000, 2000, 99, 99);
        check("thr_nextframe_edges", ff_cnt, 0);

        drive_frame(16, 8, 2, 1019, 1019, 3, 3);
        ff_cnt = 0; drive_frame(16, 8, 1, 1019, 1019, 99, 99);
        check("after_reset_edges", ff_cnt, 12);

        for (int f = 0; f < 4; f++)
            drive_frame($urandom_range(10, 24), $urandom_range(4, 9), 3,
                        $urandom_range(0, 1500), $urandom_range(0, 1500),
                        $urandom_range(0, 9), 99);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
